// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment patterns {A..G}, blank digit code and
// the capture FSM state type. Also used by the BCD->7seg encoder.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110010;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder. Unknown patterns report
// DIGIT_BLANK with invalid set; the all-off pattern reports a blank position.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        digit   = DIGIT_BLANK;
        blank   = 1'b0;
        invalid = 1'b0;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of the multiplexed 7-segment link: synchronizes the bus, waits for
// it to settle, decodes each strobed position and publishes complete frames.
module seven_segment_capture
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int STABLE_CYC  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            SEG_IN,
    input  logic [N_DIGITS-1:0]   DIG_SEL,
    input  logic                  CLR_ERR,
    output logic [4*N_DIGITS-1:0] BCD_OUT,
    output logic [N_DIGITS-1:0]   BLANK_OUT,
    output logic                  FRAME_VALID,
    output logic                  FRAME_ERR,
    output logic                  SEL_ERR,
    output logic                  ERR_STICKY,
    output logic                  STALE
);

    localparam int BUS_W  = N_DIGITS + 7;
    localparam int CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYC);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_reg;
    logic [BUS_W-1:0]                  bus_sync;
    logic [BUS_W-1:0]                  prev_reg;
    logic                              changed;

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    cap_state_e        state_reg, state_next;
    logic              capture;

    logic [N_DIGITS-1:0] cap_sel;
    logic [6:0]          cap_seg;
    logic                sel_multi, sel_onehot;
    logic [N_DIGITS-1:0] slot_we;
    logic [3:0]          dec_digit;
    logic                dec_blank, dec_invalid;

    logic [N_DIGITS-1:0][3:0] digit_reg, digit_next;
    logic [N_DIGITS-1:0]      blank_reg, blank_next;
    logic [N_DIGITS-1:0]      inv_reg, inv_next;
    logic [N_DIGITS-1:0]      seen_reg, seen_next;
    logic                     frame_done, new_err;

    logic [4*N_DIGITS-1:0] bcd_out_reg;
    logic [N_DIGITS-1:0]   blank_out_reg;
    logic                  frame_valid_reg, frame_err_reg, sel_err_reg;
    logic                  sticky_reg, stale_reg;

    assign bus_sync = sync_reg[SYNC_STAGES-1];
    assign changed  = (bus_sync != prev_reg);

    always_comb begin
        cnt_next = cnt_reg;
        if (changed) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg < CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            SEEK:   if (changed) state_next = SETTLE;
            SETTLE: if (!changed && cnt_next == CNT_MAX) state_next = CAPTURE;
            CAPTURE: begin
                capture    = 1'b1;
                state_next = changed ? SETTLE : HOLD;
            end
            HOLD:   if (changed) state_next = SETTLE;
            default: state_next = SEEK;
        endcase
    end

    // prev_reg holds the value that has been stable through SETTLE, so capture
    // uses it even if the bus starts moving again in the CAPTURE cycle.
    assign cap_sel    = prev_reg[BUS_W-1:7];
    assign cap_seg    = prev_reg[6:0];
    assign sel_multi  = |(cap_sel & (cap_sel - N_DIGITS'(1)));
    assign sel_onehot = (cap_sel != '0) && !sel_multi;

    seg_pattern_decode u_decode (
        .seg     (cap_seg),
        .digit   (dec_digit),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_slot_we
            assign slot_we[gi] = capture && sel_onehot && cap_sel[gi];
        end
    endgenerate

    always_comb begin
        digit_next = digit_reg;
        blank_next = blank_reg;
        inv_next   = inv_reg;
        seen_next  = seen_reg;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (slot_we[i]) begin
                digit_next[i] = dec_digit;
                blank_next[i] = dec_blank;
                inv_next[i]   = dec_invalid;
                seen_next[i]  = 1'b1;
            end
        end
    end

    assign frame_done = &seen_next;
    assign new_err    = (frame_done && |inv_next) || (capture && sel_multi);

    always_comb begin
        idle_next = idle_reg;
        if (capture) begin
            idle_next = '0;
        end else if (idle_reg < IDLE_MAX) begin
            idle_next = idle_reg + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg        <= '0;
            prev_reg        <= '0;
            cnt_reg         <= '0;
            idle_reg        <= '0;
            state_reg       <= SEEK;
            digit_reg       <= '0;
            blank_reg       <= '0;
            inv_reg         <= '0;
            seen_reg        <= '0;
            bcd_out_reg     <= '0;
            blank_out_reg   <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            sel_err_reg     <= 1'b0;
            sticky_reg      <= 1'b0;
            stale_reg       <= 1'b0;
        end else begin
            sync_reg[0] <= {DIG_SEL, SEG_IN};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
            prev_reg  <= bus_sync;
            cnt_reg   <= cnt_next;
            idle_reg  <= idle_next;
            state_reg <= state_next;
            digit_reg <= digit_next;
            blank_reg <= blank_next;
            // The completing capture publishes the frame and starts an empty one.
            if (frame_done) begin
                seen_reg      <= '0;
                inv_reg       <= '0;
                bcd_out_reg   <= digit_next;
                blank_out_reg <= blank_next;
            end else begin
                seen_reg <= seen_next;
                inv_reg  <= inv_next;
            end
            frame_valid_reg <= frame_done;
            frame_err_reg   <= frame_done && |inv_next;
            sel_err_reg     <= capture && sel_multi;
            if (new_err) begin
                sticky_reg <= 1'b1;
            end else if (CLR_ERR) begin
                sticky_reg <= 1'b0;
            end
            stale_reg <= (idle_next == IDLE_MAX);
        end
    end

    assign BCD_OUT     = bcd_out_reg;
    assign BLANK_OUT   = blank_out_reg;
    assign FRAME_VALID = frame_valid_reg;
    assign FRAME_ERR   = frame_err_reg;
    assign SEL_ERR     = sel_err_reg;
    assign ERR_STICKY  = sticky_reg;
    assign STALE       = stale_reg;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: directed scenarios plus random
// dwell/ghost traffic checked against a table-driven frame model.
module tb_seven_segment_capture;

    localparam int N   = 4;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg_in = '0;
    logic [N-1:0]   dig_sel = '0;
    logic           clr_err = 1'b0;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]   blank_out;
    logic           frame_valid, frame_err, sel_err, err_sticky, stale;

    always #5 clk = ~clk;

    seven_segment_capture #(
        .N_DIGITS(N), .STABLE_CYC(8), .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SEG_IN(seg_in), .DIG_SEL(dig_sel), .CLR_ERR(clr_err),
        .BCD_OUT(bcd_out), .BLANK_OUT(blank_out), .FRAME_VALID(frame_valid),
        .FRAME_ERR(frame_err), .SEL_ERR(sel_err), .ERR_STICKY(err_sticky), .STALE(stale)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pattern table lookup and a per-position frame store.
    logic [6:0] pat_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};

    typedef struct {
        bit         is_sel;
        logic [15:0] bcd;
        logic [3:0]  blank;
        bit          err;
    } ev_t;

    ev_t        exp_q[$];
    bit [N-1:0] m_seen = '0;
    logic [3:0] m_digit [N];
    bit         m_blank [N];
    bit         m_inv   [N];
    bit         m_sticky = 1'b0;
    logic [N-1:0] cur_sel = '0;
    logic [6:0]   cur_seg = '0;

    function automatic void model_decode(input logic [6:0] p, output logic [3:0] d,
                                         output bit b, output bit inv);
        d = 4'hF; b = 1'b0; inv = 1'b1;
        if (p == 7'd0) begin
            b = 1'b1; inv = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (pat_tbl[k] == p) begin
                d = k[3:0]; inv = 1'b0;
            end
        end
    endfunction

    task automatic model_capture(input logic [N-1:0] sel, input logic [6:0] seg);
        ev_t e;
        int  pos;
        if (sel == '0) return;
        if ($countones(sel) > 1) begin
            e.is_sel = 1'b1; e.bcd = '0; e.blank = '0; e.err = 1'b0;
            exp_q.push_back(e);
            m_sticky = 1'b1;
            return;
        end
        pos = 0;
        for (int k = 0; k < N; k++) if (sel[k]) pos = k;
        model_decode(seg, m_digit[pos], m_blank[pos], m_inv[pos]);
        m_seen[pos] = 1'b1;
        if (&m_seen) begin
            e.is_sel = 1'b0; e.err = 1'b0;
            for (int k = 0; k < N; k++) begin
                e.bcd[4*k +: 4] = m_digit[k];
                e.blank[k]      = m_blank[k];
                e.err           = e.err | m_inv[k];
                m_inv[k]        = 1'b0;
            end
            exp_q.push_back(e);
            if (e.err) m_sticky = 1'b1;
            m_seen = '0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] sel, input logic [6:0] seg);
        dig_sel = sel; seg_in = seg; cur_sel = sel; cur_seg = seg;
    endtask

    task automatic hold(input logic [N-1:0] sel, input logic [6:0] seg, input int len);
        model_capture(sel, seg);
        drive(sel, seg);
        tick(len);
        check("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
        check("stale_active", {31'd0, stale}, 32'd0);
    endtask

    task automatic gap();
        logic [6:0] p;
        p = 7'($urandom);
        if (cur_sel == '0 && p == cur_seg) p = p ^ 7'h1;
        drive('0, p);
        tick(3);
    endtask

    task automatic ghost_burst(input int n);
        for (int g = 0; g < n; g++) begin
            logic [N-1:0] s;
            logic [6:0]   p;
            s = N'($urandom);
            p = 7'($urandom);
            if (s == cur_sel && p == cur_seg) p = p ^ 7'h1;
            drive(s, p);
            tick($urandom_range(1, 4));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"},    32'(bcd_out), 32'd0);
        check({tag, "_blank"},  32'(blank_out), 32'd0);
        check({tag, "_fvalid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_ferr"},   {31'd0, frame_err}, 32'd0);
        check({tag, "_selerr"}, {31'd0, sel_err}, 32'd0);
        check({tag, "_sticky"}, {31'd0, err_sticky}, 32'd0);
        check({tag, "_stale"},  {31'd0, stale}, 32'd0);
    endtask

    // Monitor: every FRAME_VALID / SEL_ERR pulse is matched against the queue head.
    ev_t mon_ev;
    always @(negedge clk) begin
        if (rst_n && (frame_valid || sel_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, frame_valid, sel_err}, 32'd0);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.is_sel) begin
                    $display("event sel_err t=%0t", $time);
                    check("event_kind_sel", {30'd0, frame_valid, sel_err}, 32'd1);
                end else begin
                    $display("event frame bcd=%h blank=%b err=%b t=%0t",
                             bcd_out, blank_out, frame_err, $time);
                    check("event_kind_frame", {30'd0, frame_valid, sel_err}, 32'd2);
                    check("frame_bcd",   32'(bcd_out), 32'(mon_ev.bcd));
                    check("frame_blank", 32'(blank_out), 32'(mon_ev.blank));
                    check("frame_err",   {31'd0, frame_err}, {31'd0, mon_ev.err});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b;
        for (int k = 0; k < N; k++) begin
            m_digit[k] = '0; m_blank[k] = 1'b0; m_inv[k] = 1'b0;
        end

        // Reset state
        tick(4);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(5);

        // Encoder loopback 1,2,3,4
        for (int k = 0; k < N; k++) begin
            hold(N'(1 << k), pat_tbl[k + 1], 20);
            gap();
        end
        check("loopback_bcd", 32'(bcd_out), 32'h4321);
        check("loopback_blank", 32'(blank_out), 32'd0);

        // Ghost filter: strobe/segment flicker every 3 cycles, then digit 7 at position 3
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive(4'b0100, pat_tbl[2]);
            else            drive(4'b0110, pat_tbl[5]);
            tick(3);
        end
        hold(4'b1000, 7'b1110010, 20);
        for (int k = 0; k < 3; k++) begin
            gap();
            hold(N'(1 << k), pat_tbl[8], 20);
        end
        b = bcd_out;
        check("ghost_digit3", 32'(b[15:12]), 32'h7);

        // Invalid and blank patterns
        gap(); hold(4'b0100, 7'b0000001, 20);
        gap(); hold(4'b0001, 7'b0000000, 20);
        gap(); hold(4'b0010, pat_tbl[5], 20);
        gap(); hold(4'b1000, pat_tbl[9], 20);
        check("invblank_bcd", 32'(bcd_out), 32'h9F5F);
        check("invblank_blank", 32'(blank_out), 32'b0001);
        tick(10);
        check("sticky_held", {31'd0, err_sticky}, 32'd1);
        clr_err = 1'b1; tick(1); clr_err = 1'b0; m_sticky = 1'b0;
        check("sticky_cleared", {31'd0, err_sticky}, 32'd0);

        // Strobe errors: multi-hot and all-zero
        gap(); hold(4'b0110, pat_tbl[3], 16);
        clr_err = 1'b1; tick(1); clr_err = 1'b0; m_sticky = 1'b0;
        gap(); hold(4'b0000, pat_tbl[3], 16);

        // Timeout
        gap(); hold(4'b0001, pat_tbl[6], 20);
        tick(40);
        check("stale_early", {31'd0, stale}, 32'd0);
        tick(80);
        check("stale_asserted", {31'd0, stale}, 32'd1);
        gap(); hold(4'b0010, pat_tbl[4], 20);

        // Reset mid-frame (two positions seen, sticky set)
        gap(); hold(4'b1100, pat_tbl[1], 16);
        gap();
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_seen = '0; m_sticky = 1'b0;
        for (int k = 0; k < N; k++) m_inv[k] = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        hold(4'b0100, pat_tbl[0], 20); gap();
        hold(4'b1000, pat_tbl[9], 20); gap();
        hold(4'b0001, pat_tbl[7], 20); gap();
        hold(4'b0010, pat_tbl[3], 20); gap();
        check("after_reset_bcd", 32'(bcd_out), 32'h9037);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            logic [N-1:0] s;
            logic [6:0]   p;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       s = N'(1 << $urandom_range(0, N - 1));
            else if (r == 7) s = '0;
            else begin
                s = N'($urandom);
                while ($countones(s) < 2) s = N'($urandom);
            end
            r = $urandom_range(0, 19);
            if (r < 14)      p = pat_tbl[$urandom_range(0, 9)];
            else if (r < 17) p = 7'd0;
            else             p = 7'($urandom);
            hold(s, p, $urandom_range(16, 24));
            if ($urandom_range(0, 2) == 0) ghost_burst($urandom_range(1, 5));
            gap();
            if ($urandom_range(0, 3) == 0) begin
                clr_err = 1'b1; tick(1); clr_err = 1'b0; m_sticky = 1'b0;
            end
        end

        tick(30);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
